fifo_param: RTL and testbench

Parametrised synchronous FIFO, the generalised successor to the team's fixed 16x8 byte FIFO. Width and depth are set by parameters. It adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in one clock domain, such as UART TX/RX buffering and command queues.

---
 rtl/fifo_param.sv | 139 +++++++++++++
 tb/tb_fifo_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky error flags.
//
// Ports:
//   clock_in          system clock, all state changes on the rising edge
//   n_reset_in        asynchronous active-low reset
//   write_in/wdata_in write request and the word to enqueue
//   read_in           read request; rdata_out is registered (1-cycle latency)
//   flush_in          synchronous flush, overrides read and write
//   clear_err_in      synchronous clear of overflow_out/underflow_out
//   readable_out      count != 0
//   writable_out      count != DEPTH
//   count_out         occupancy, 0..DEPTH
//   almost_full_out   count >= AFULL_LEVEL
//   almost_empty_out  count <= AEMPTY_LEVEL
//   overflow_out      sticky, a write was rejected
//   underflow_out     sticky, a read was rejected
module fifo_param #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned AFULL_LEVEL  = 12,
    parameter int unsigned AEMPTY_LEVEL = 4
) (
    input  logic                  clock_in,
    input  logic                  n_reset_in,
    input  logic                  write_in,
    input  logic [WIDTH-1:0]      wdata_in,
    input  logic                  read_in,
    output logic [WIDTH-1:0]      rdata_out,
    input  logic                  flush_in,
    input  logic                  clear_err_in,
    output logic                  readable_out,
    output logic                  writable_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  almost_full_out,
    output logic                  almost_empty_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // Thresholds sized to the count register so comparisons are width-matched.
    localparam logic [DEPTH_LOG2:0] DepthCnt  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AfullCnt  = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);
    localparam logic [DEPTH_LOG2:0] AemptyCnt = (DEPTH_LOG2 + 1)'(AEMPTY_LEVEL);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic rd_accept;
    logic wr_accept;
    logic full;

    assign full      = (count_q == DepthCnt);
    assign rd_accept = read_in && (count_q != '0) && !flush_in;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign wr_accept = write_in && !flush_in && (!full || rd_accept);

    always_comb begin
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush_in) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (rd_accept) begin
                rdata_d = mem_q[rptr_q];
                rptr_d  = rptr_q + 1'b1;
            end
            if (wr_accept) begin
                wptr_d = wptr_q + 1'b1;
            end
            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Set beats clear when both happen on the same edge.
        if (clear_err_in) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write_in && !flush_in && !wr_accept) begin
            overflow_d = 1'b1;
        end
        if (read_in && !flush_in && !rd_accept) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clock_in) begin
        if (wr_accept) begin
            mem_q[wptr_q] <= wdata_in;
        end
    end

    assign rdata_out        = rdata_q;
    assign count_out        = count_q;
    assign readable_out     = (count_q != '0);
    assign writable_out     = !full;
    assign almost_full_out  = (count_q >= AfullCnt);
    assign almost_empty_out = (count_q <= AemptyCnt);
    assign overflow_out     = overflow_q;
    assign underflow_out    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model after every clock edge.
module tb_fifo_param;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned DEPTH_LOG2   = 4;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned AFULL_LEVEL  = 12;
    localparam int unsigned AEMPTY_LEVEL = 4;

    logic                clock_in = 1'b0;
    logic                n_reset_in;
    logic                write_in;
    logic [WIDTH-1:0]    wdata_in;
    logic                read_in;
    logic [WIDTH-1:0]    rdata_out;
    logic                flush_in;
    logic                clear_err_in;
    logic                readable_out;
    logic                writable_out;
    logic [DEPTH_LOG2:0] count_out;
    logic                almost_full_out;
    logic                almost_empty_out;
    logic                overflow_out;
    logic                underflow_out;

    fifo_param #(
        .WIDTH        (WIDTH),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .AFULL_LEVEL  (AFULL_LEVEL),
        .AEMPTY_LEVEL (AEMPTY_LEVEL)
    ) dut (
        .clock_in         (clock_in),
        .n_reset_in       (n_reset_in),
        .write_in         (write_in),
        .wdata_in         (wdata_in),
        .read_in          (read_in),
        .rdata_out        (rdata_out),
        .flush_in         (flush_in),
        .clear_err_in     (clear_err_in),
        .readable_out     (readable_out),
        .writable_out     (writable_out),
        .count_out        (count_out),
        .almost_full_out  (almost_full_out),
        .almost_empty_out (almost_empty_out),
        .overflow_out     (overflow_out),
        .underflow_out    (underflow_out)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a plain queue, plus the registered outputs.
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] model_rdata;
    logic             model_ovf;
    logic             model_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_rdata = '0;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [WIDTH-1:0] wd, input logic r,
                              input logic fl, input logic clr);
        bit rd_ok, wr_ok, set_o, set_u;
        rd_ok = 0;
        wr_ok = 0;
        set_o = 0;
        set_u = 0;
        if (fl) begin
            model_q.delete();
        end else begin
            rd_ok = r && (model_q.size() != 0);
            wr_ok = w && ((model_q.size() != DEPTH) || rd_ok);
            set_o = w && !wr_ok;
            set_u = r && !rd_ok;
            if (rd_ok) model_rdata = model_q.pop_front();
            if (wr_ok) model_q.push_back(wd);
        end
        if (clr) begin
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end
        if (set_o) model_ovf = 1'b1;
        if (set_u) model_unf = 1'b1;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ":count"},  32'(count_out),        32'(n));
        check({tag, ":rdable"}, 32'(readable_out),     32'(n != 0));
        check({tag, ":wrable"}, 32'(writable_out),     32'(n != DEPTH));
        check({tag, ":afull"},  32'(almost_full_out),  32'(n >= AFULL_LEVEL));
        check({tag, ":aempty"}, 32'(almost_empty_out), 32'(n <= AEMPTY_LEVEL));
        check({tag, ":rdata"},  32'(rdata_out),        32'(model_rdata));
        check({tag, ":ovf"},    32'(overflow_out),     32'(model_ovf));
        check({tag, ":unf"},    32'(underflow_out),    32'(model_unf));
    endtask

    // Inputs are applied 1ns after an edge; outputs are checked 1ns after the next.
    task automatic step(input logic w, input logic [WIDTH-1:0] wd, input logic r,
                        input logic fl, input logic clr, input string tag);
        write_in     = w;
        wdata_in     = wd;
        read_in      = r;
        flush_in     = fl;
        clear_err_in = clr;
        @(posedge clock_in);
        model_step(w, wd, r, fl, clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        write_in     = 1'b0;
        wdata_in     = '0;
        read_in      = 1'b0;
        flush_in     = 1'b0;
        clear_err_in = 1'b0;
    endtask

    initial begin
        int wp;
        idle_inputs();
        n_reset_in = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        n_reset_in = 1'b1;

        // Fill with 0x01..0x10, then a rejected 17th write.
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0, "fill");
        check("full_count", 32'(count_out), 32'd16);
        step(1, 8'hEE, 0, 0, 0, "fill_over");
        check("over_flag", 32'(overflow_out), 32'd1);

        // Drain in order, then a rejected read.
        for (int i = 1; i <= 16; i++) begin
            step(0, '0, 1, 0, 0, "drain");
            check("drain_data", 32'(rdata_out), 32'(i));
        end
        step(0, '0, 1, 0, 0, "drain_under");
        check("under_hold", 32'(rdata_out), 32'h10);

        // Clear flags, then simultaneous read/write while full.
        step(0, '0, 0, 0, 1, "clr");
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0, "refill");
        step(1, 8'hAA, 1, 0, 0, "full_rw");
        check("full_rw_data", 32'(rdata_out), 32'h01);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0, "full_rw_drain");
        check("aa_last", 32'(rdata_out), 32'hAA);

        // Simultaneous read/write while empty.
        step(1, 8'h5C, 1, 0, 0, "empty_rw");
        step(0, '0, 1, 0, 0, "empty_rw_read");
        check("5c_out", 32'(rdata_out), 32'h5C);
        step(0, '0, 0, 0, 1, "clr2");

        // Wrap-around.
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0, 0, "wrap_w");
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0, 0, "wrap_r");
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, "wrap_w2");
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0, "wrap_r2");

        // Flush with count 7 overrides read and write.
        for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + i), 0, 0, 0, "pre_flush");
        step(1, 8'h99, 1, 1, 0, "flush");

        // Error clear, and set-beats-clear.
        for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0, 0, "ovf_fill");
        step(0, '0, 0, 0, 1, "ovf_clear");
        step(1, 8'h11, 0, 0, 1, "ovf_setwins");
        check("setwins", 32'(overflow_out), 32'd1);
        step(0, '0, 0, 1, 1, "flush_clr");

        // Randomized traffic with alternating write/read bias.
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph % 2 == 0) ? 70 : 30;
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < wp, 8'($urandom),
                     $urandom_range(0, 99) < (100 - wp),
                     $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, "rand");
            end
        end

        // Asynchronous reset in the middle of a burst, away from any edge.
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 1, 0, 0, "burst");
        #2;
        n_reset_in = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        idle_inputs();
        #1;
        n_reset_in = 1'b1;
        step(1, 8'h77, 0, 0, 0, "post_rst_w");
        step(0, '0, 1, 0, 0, "post_rst_r");
        check("post_rst_data", 32'(rdata_out), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
